// File: rtl/tm1640_pkg.sv
// tm1640_pkg: shared constants, state encoding and byte selection for the TM1640 writer.
package tm1640_pkg;
    localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
    localparam logic [7:0] POS_CMD_ONLY = 8'hFF;
    localparam int PHASES_CMD = 20;
    localparam int PHASES_SEG = 36;
    localparam int PHASES_DATA = 57;

    typedef enum logic [2:0] {IDLE, START, BIT_LO, BIT_HI, STOP0, STOP1, STOP2, GAP} state_t;

    // Byte 0 is the lone command byte of the first segment; bytes 1..2 form the data segment.
    function automatic logic [7:0] seg_byte(input logic [1:0] idx, input logic [7:0] p, input logic [7:0] v);
        return idx == 2'd1 ? p : idx == 2'd2 ? v : (p == POS_CMD_ONLY ? v : CMD_DATA_FIXED);
    endfunction
endpackage

// File: rtl/tm1640_writer_phase_timer.sv
// phase_timer: CLK_DIV-cycle down-counter giving a one-cycle phase_end pulse; restart begins a fresh phase.
module phase_timer #(
    parameter int CLK_DIV = 25
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic phase_end
);
    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (restart || cnt_q == 16'd0) ? RELOAD : cnt_q - 16'd1;
    end

    assign phase_end = cnt_q == 16'd0;

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= 16'd0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tm1640_writer.sv
// tm1640_writer: serialises one TM1640 command-only or fixed-address data write per accepted request.
module tm1640_writer
    import tm1640_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       valid,
    input  logic [7:0] pos,
    input  logic [7:0] value,
    output logic       o_SCLK,
    output logic       o_DIN,
    output logic       busy
);
    state_t state_q, state_d;
    logic [1:0] byte_q, byte_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] pos_q, pos_d, value_q, value_d, cur;
    logic busy_q, busy_d, sclk_q, sclk_d, din_q, din_d;
    logic restart, phase_end;

    phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .CLK(CLK),
        .RST(RST),
        .restart(restart),
        .phase_end(phase_end)
    );

    always_comb begin
        state_d = state_q;
        byte_d = byte_q;
        bit_d = bit_q;
        pos_d = pos_q;
        value_d = value_q;
        busy_d = busy_q;
        restart = 1'b0;
        if (state_q == IDLE) begin
            if (valid) begin
                state_d = START;
                pos_d = pos;
                value_d = value;
                busy_d = 1'b1;
                restart = 1'b1;
            end
        end else if (phase_end) begin
            case (state_q)
                START: state_d = BIT_LO;
                BIT_LO: state_d = BIT_HI;
                BIT_HI: begin
                    bit_d = bit_q + 3'd1;
                    state_d = (bit_q != 3'd7 || byte_q == 2'd1) ? BIT_LO : STOP0;
                    byte_d = (bit_q == 3'd7 && byte_q == 2'd1) ? 2'd2 : byte_q;
                end
                STOP0: state_d = STOP1;
                STOP1: state_d = STOP2;
                STOP2: begin
                    // The data segment follows only after the fixed-address command segment.
                    if (pos_q != POS_CMD_ONLY && byte_q == 2'd0) begin
                        state_d = GAP;
                        byte_d = 2'd1;
                    end else begin
                        state_d = IDLE;
                        busy_d = 1'b0;
                        byte_d = 2'd0;
                    end
                end
                GAP: state_d = START;
                default: state_d = IDLE;
            endcase
        end
        cur = seg_byte(byte_d, pos_d, value_d);
        sclk_d = !(state_d == BIT_LO || state_d == STOP0);
        din_d = (state_d == BIT_LO || state_d == BIT_HI) ? cur[bit_d]
              : !(state_d == START || state_d == STOP0 || state_d == STOP1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            byte_q <= 2'd0;
            bit_q <= 3'd0;
            pos_q <= 8'd0;
            value_q <= 8'd0;
            busy_q <= 1'b0;
            sclk_q <= 1'b1;
            din_q <= 1'b1;
        end else begin
            state_q <= state_d;
            byte_q <= byte_d;
            bit_q <= bit_d;
            pos_q <= pos_d;
            value_q <= value_d;
            busy_q <= busy_d;
            sclk_q <= sclk_d;
            din_q <= din_d;
        end
    end

    assign o_SCLK = sclk_q;
    assign o_DIN = din_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_tm1640_writer.sv
// tb_tm1640_writer: randomized and directed transfers compared against a phase-level waveform and byte-decode model.
module tb_tm1640_writer;
    localparam int DIV = 4;

    logic CLK = 1'b0, RST = 1'b1, valid = 1'b0;
    logic [7:0] pos = 8'd0, value = 8'd0;
    logic o_SCLK, o_DIN, busy;

    tm1640_writer #(.CLK_DIV(DIV)) dut (
        .CLK(CLK),
        .RST(RST),
        .valid(valid),
        .pos(pos),
        .value(value),
        .o_SCLK(o_SCLK),
        .o_DIN(o_DIN),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int vectors = 0, miscompares = 0, xfers = 0;
    logic [1:0] wave[$], last_wave[$], exp_wave[$];
    int dec[$], last_dec[$], exp_dec[$];
    logic p_sclk = 1'b1, p_din = 1'b1, p_busy = 1'b0, in_seg = 1'b0;
    int nbits = 0;
    logic [7:0] sh = 8'd0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: decodes START/STOP/bits and records each busy window.
    always @(negedge CLK) begin
        if (RST) begin
            wave.delete();
            dec.delete();
            in_seg = 1'b0;
            nbits = 0;
            p_sclk = 1'b1;
            p_din = 1'b1;
            p_busy = 1'b0;
        end else begin
            if (p_sclk && o_SCLK && p_din != o_DIN) begin
                if (!o_DIN) begin
                    check("start_outside_seg", int'(in_seg), 0);
                    in_seg = 1'b1;
                    nbits = 0;
                end else begin
                    check("stop_inside_seg", int'(in_seg), 1);
                    check("stop_bit_align", nbits % 8, 1);
                    in_seg = 1'b0;
                    dec.push_back(256);
                end
            end
            if (!p_sclk && o_SCLK) begin
                sh = {o_DIN, sh[7:1]};
                nbits++;
                if (nbits % 8 == 0) dec.push_back(int'(sh));
            end
            if (busy) wave.push_back({o_SCLK, o_DIN});
            if (p_busy && !busy) begin
                last_wave = wave;
                last_dec = dec;
                wave.delete();
                dec.delete();
                xfers++;
            end
            p_sclk = o_SCLK;
            p_din = o_DIN;
            p_busy = busy;
        end
    end

    task automatic add_phase(input logic s, input logic d);
        repeat (DIV) exp_wave.push_back({s, d});
    endtask

    task automatic add_seg(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [7:0] b;
        add_phase(1'b1, 1'b0);
        for (int k = 0; k < n; k++) begin
            b = (k == 0) ? b0 : b1;
            for (int i = 0; i < 8; i++) begin
                add_phase(1'b0, b[i]);
                add_phase(1'b1, b[i]);
            end
            exp_dec.push_back(int'(b));
        end
        add_phase(1'b0, 1'b0);
        add_phase(1'b1, 1'b0);
        add_phase(1'b1, 1'b1);
        exp_dec.push_back(256);
    endtask

    task automatic compare(input logic [7:0] p, input logic [7:0] v);
        int m;
        exp_wave.delete();
        exp_dec.delete();
        if (p == 8'hFF) add_seg(v, 8'd0, 1);
        else begin
            add_seg(8'h44, 8'd0, 1);
            add_phase(1'b1, 1'b1);
            add_seg(p, v, 2);
        end
        check("busy_cycles", last_wave.size(), (p == 8'hFF ? 20 : 57) * DIV);
        check("wave_len", last_wave.size(), exp_wave.size());
        m = 0;
        for (int i = 0; i < exp_wave.size() && i < last_wave.size(); i++)
            if (last_wave[i] != exp_wave[i]) m++;
        check("wave_diff", m, 0);
        check("dec_len", last_dec.size(), exp_dec.size());
        for (int i = 0; i < exp_dec.size(); i++)
            if (i < last_dec.size()) check("dec_byte", last_dec[i], exp_dec[i]);
    endtask

    task automatic send(input logic [7:0] p, input logic [7:0] v);
        @(posedge CLK);
        #1;
        valid = 1'b1;
        pos = p;
        value = v;
        @(posedge CLK);
        #1;
        valid = 1'b0;
        check("busy_rise", int'(busy), 1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 2000 && xfers < target; i++) @(posedge CLK);
        #2;
        check("done_timeout", int'(xfers >= target), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t;
        logic [7:0] p, v;
        valid = 1'b1;
        pos = 8'hFF;
        value = 8'h12;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        valid = 1'b0;
        @(negedge CLK);
        check("rst_busy", int'(busy), 0);
        check("rst_sclk", int'(o_SCLK), 1);
        check("rst_din", int'(o_DIN), 1);

        n = xfers;
        send(8'hFF, 8'h89);
        wait_done(n + 1);
        compare(8'hFF, 8'h89);

        n = xfers;
        send(8'hC3, 8'hA5);
        wait_done(n + 1);
        compare(8'hC3, 8'hA5);

        n = xfers;
        send(8'hC3, 8'hA5);
        repeat (9) @(posedge CLK);
        #1;
        valid = 1'b1;
        pos = 8'hFF;
        value = 8'h00;
        @(posedge CLK);
        #1;
        valid = 1'b0;
        wait_done(n + 1);
        compare(8'hC3, 8'hA5);
        repeat (40) @(posedge CLK);
        #1;
        check("single_xfer", xfers, n + 1);
        check("idle_after_ignored", int'(busy), 0);

        n = xfers;
        @(posedge CLK);
        #1;
        valid = 1'b1;
        pos = 8'hFF;
        value = 8'h3C;
        t = 0;
        do begin @(negedge CLK); t++; end while (!busy && t < 20);
        do begin @(negedge CLK); t++; end while (busy && t < 400);
        check("b2b_idle_seen", int'(busy), 0);
        @(negedge CLK);
        check("b2b_restart", int'(busy), 1);
        valid = 1'b0;
        wait_done(n + 1);
        compare(8'hFF, 8'h3C);
        wait_done(n + 2);
        compare(8'hFF, 8'h3C);

        n = xfers;
        send(8'hC0, 8'($urandom));
        repeat (48) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_sclk", int'(o_SCLK), 1);
        check("abort_din", int'(o_DIN), 1);
        check("abort_no_xfer", xfers, n);
        send(8'hFF, 8'h8F);
        wait_done(n + 1);
        compare(8'hFF, 8'h8F);

        for (int k = 0; k < 12; k++) begin
            p = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            v = 8'($urandom);
            n = xfers;
            send(p, v);
            wait_done(n + 1);
            compare(p, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tm1640_writer.md
TM1640_WRITER -- requirements
Module: tm1640_writer

Interface
REQ-001 Parameter CLK_DIV, default 25, system clocks per protocol phase (half bit); 25 MHz / (2*25) = 500 kHz bit rate; legal range 2..65535.
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 valid  input  1  one-cycle request strobe; sampled only while busy=0.
REQ-005 pos  input  8  TM1640 address command (0xC0..0xCF), or 0xFF = command-only transfer.
REQ-006 value  input  8  display data byte, or the command byte when pos=0xFF.
REQ-007 o_SCLK  output  1  TM1640 serial clock.
REQ-008 o_DIN  output  1  TM1640 serial data.
REQ-009 busy  output  1  high while a transfer is in progress.

Function
REQ-010 Request accepted on the rising edge where valid=1 and busy=0; pos/value captured in internal registers on that edge.
REQ-011 busy goes high on that same edge, so it is visible the next cycle; valid while busy=1 is ignored and changes nothing.
REQ-012 Phase = exactly CLK_DIV cycles, timed by a phase counter that reloads at each phase boundary.
REQ-013 Idle levels: o_SCLK=1, o_DIN=1.
REQ-014 Segment = START, N bytes, STOP.
REQ-015 START: one phase with o_SCLK=1, o_DIN=0.
REQ-016 Byte: 8 bits, LSB first, each bit two phases: (o_SCLK=0, o_DIN=bit), then (o_SCLK=1, o_DIN=bit). o_DIN changes only while o_SCLK=0.
REQ-017 STOP: three phases (SCLK=0,DIN=0), (SCLK=1,DIN=0), (SCLK=1,DIN=1).
REQ-018 pos=0xFF: one segment [value]; 20 phases total.
REQ-019 pos!=0xFF: segment [0x44] (fixed-address data command), then one idle phase (SCLK=1, DIN=1), then segment [pos, value]; 20+1+36 = 57 phases total.
REQ-020 busy falls on the edge that ends the final STOP phase; back-to-back requests are accepted the next cycle.
REQ-021 States: IDLE, START, BIT_LO, BIT_HI, STOP0, STOP1, STOP2, GAP; byte index 0..2 and bit index 0..7 counters select the shifted byte.
REQ-022 Transitions: IDLE->START on accept; BIT_HI->BIT_LO while bit<7; after bit 7 -> BIT_LO of the next byte in the segment, else STOP0; STOP2->GAP if the data segment is still pending, else IDLE; GAP->START.
REQ-023 pos values other than 0xFF are sent verbatim; no range check.
REQ-024 Outputs are registered; no combinational path from inputs to o_SCLK, o_DIN or busy.

Reset
REQ-025 On an edge with RST=1: state=IDLE, busy=0, o_SCLK=1, o_DIN=1, counters=0, captured registers=0.
REQ-026 RST mid-transfer aborts it immediately with no STOP sequence; the next accepted request starts with a fresh START.
REQ-027 valid asserted in the same cycle as RST is dropped.

Structure
REQ-028 Shared package tm1640_pkg holds CMD_DATA_FIXED=8'h44, POS_CMD_ONLY=8'hFF, the state enum and the phase counts (20, 36, 57).
REQ-029 One sub-module, phase_timer, holds the CLK_DIV down-counter with a one-cycle phase_end pulse and a restart input.

Verification
REQ-030 CLK_DIV=4, valid with pos=0xFF, value=0x89 -> busy high for 80 cycles; decoded DIN bits 1,0,0,1,0,0,0,1; START and STOP present.
REQ-031 CLK_DIV=4, pos=0xC3, value=0xA5 -> bytes 0x44 | gap | 0xC3,0xA5 decoded; busy high for 228 cycles.
REQ-032 valid pulsed again 10 cycles into a transfer -> ignored; waveform identical to REQ-031; exactly one transfer.
REQ-033 valid held high across busy falling -> second transfer starts the cycle after busy=0; no idle gap beyond the protocol.
REQ-034 RST asserted at cycle 50 of a pos=0xC0 transfer -> next cycle busy=0, SCLK=1, DIN=1; a following pos=0xFF, value=0x8F transfer decodes correctly.
REQ-035 Protocol checker throughout: DIN never toggles while SCLK=1, except at START and STOP edges.
